fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO between NREQ requesters in the write clock domain.
- A grant is held for a whole packet (until a beat with req_last, or MAX_BURST beats) so packets from different requesters never interleave in the FIFO.
- Write-side backpressure is taken from the FIFO full_flag.
- Drives the FIFO wr_en/wr_data and returns per-requester ready.

Parameters:
- WIDTH, 8, data width; matches the FIFO WIDTH.
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum beats per grant before forced release (>=1).

Ports:
- clk  input  1  write-domain clock; connects to the FIFO wr_clk.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_last  input  NREQ  marks the final beat of a packet.
- req_ready  output  NREQ  beat accepted this cycle when req_valid[i] & req_ready[i].
- full_flag  input  1  FIFO full flag.
- wr_en  output  1  FIFO write enable.
- wr_data  output  WIDTH  FIFO write data.
- grant  output  NREQ  one-hot registered current owner; all-zero when idle.
- pkt_done  output  1  one-cycle registered pulse after a grant is released.

Behaviour:
- Reset: synchronous on the rising edge of clk while rst=1.
  - state=IDLE, grant=0, beat_cnt=0, last_idx=NREQ-1 (so requester 0 has first priority), pkt_done=0.
  - wr_en=0 and req_ready=0 while state=IDLE.
  - Reset mid-burst abandons the packet; no further beats are written after the reset edge.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is set, pick the first i with req_valid[i]=1, searching circularly from last_idx+1.
  - Register grant=onehot(i) and beat_cnt=0, then go to BURST next cycle.
  - If no req_valid, stay in IDLE.
  - No writes occur in IDLE: one bubble cycle per arbitration.
- BURST with owner g (combinational outputs):
  - accept = req_valid[g] & ~full_flag.
  - wr_en = accept.
  - wr_data = req_data[g].
  - req_ready[g] = ~full_flag; req_ready[j≠g] = 0.
  - req_valid[g]=0 mid-packet: hold BURST and wait; the grant is not released.
  - full_flag=1: wr_en=0 and the beat is held; no beat is lost or duplicated.
- Release: on an accepted beat with req_last[g]=1, or with beat_cnt==MAX_BURST-1:
  - next cycle state=IDLE, grant=0, last_idx=g, beat_cnt=0, pkt_done=1 for one cycle.
  - Otherwise each accepted beat increments beat_cnt.
- beat_cnt width is clog2(MAX_BURST)+1; it never wraps because release occurs at MAX_BURST-1.
- Requests from non-owners are ignored during BURST; they win in later arbitrations in round-robin order.
- A requester whose req_valid drops in IDLE is not granted; selection is based only on the IDLE-cycle sample.
- Throughput: with full_flag=0, one beat per clk during BURST; L beats cost L+1 cycles.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat packet (A0,A1,A2, last on A2), full_flag=0 -> grant=0001 one cycle after valid; wr_en high 3 consecutive cycles with A0..A2; pkt_done pulses once; grant returns to 0.
- All four requesters valid, each sending 2-beat packets -> FIFO write order is req0,req1,req2,req3,req0; one idle cycle between packets; no interleaving.
- req1 mid-packet, full_flag asserted 4 cycles after beat 1 -> wr_en=0 and req_ready[1]=0 during those 4 cycles; beat 2 written exactly once after full_flag falls.
- MAX_BURST=16, req2 streams 20 beats with no last -> release after 16 writes; req3 (valid) is granted next; req2 regains the grant afterwards for its remaining 4 beats.
- rst=1 asserted on beat 2 of a 5-beat packet -> state IDLE and wr_en=0 from the next edge; after reset, req0 wins if several requesters are valid.
- Owner req_valid drops for 3 cycles mid-packet while others are valid -> grant stays on the owner; no foreign beats written; the packet completes.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, FIFO write-port and status signals for fifo_wr_arbiter.
// master is the arbiter's view of the bundle; slave is the view of the requesters and FIFO.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  full_flag;
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic [NREQ-1:0]       grant;
    logic                  pkt_done;

    modport master (
        input  req_valid, req_data, req_last, full_flag,
        output req_ready, wr_en, wr_data, grant, pkt_done
    );

    modport slave (
        output req_valid, req_data, req_last, full_flag,
        input  req_ready, wr_en, wr_data, grant, pkt_done
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter feeding the write port of a FIFO.
// A grant is held until the owner's last beat or MAX_BURST beats, then re-arbitrated.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] r_grant, w_grant_next;
    logic [IW-1:0]   r_owner, w_owner_next;
    logic [IW-1:0]   r_last_idx, w_last_idx_next;
    logic [CW-1:0]   r_beat_cnt, w_beat_cnt_next;
    logic            r_pkt_done, w_pkt_done_next;

    logic            w_pick_any;
    logic [IW-1:0]   w_pick_idx;
    logic [IW-1:0]   w_cand;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;

    // Descending search so the nearest valid requester after r_last_idx is the final assignment.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(r_last_idx) + k) % NREQ);
            if (bus.req_valid[w_cand]) begin
                w_pick_any = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_owner_next    = r_owner;
        w_last_idx_next = r_last_idx;
        w_beat_cnt_next = r_beat_cnt;
        w_pkt_done_next = 1'b0;
        w_accept        = 1'b0;
        w_req_ready     = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_next             = BURST;
                    w_grant_next             = '0;
                    w_grant_next[w_pick_idx] = 1'b1;
                    w_owner_next             = w_pick_idx;
                    w_beat_cnt_next          = '0;
                end
            end
            BURST: begin
                w_req_ready[r_owner] = ~bus.full_flag;
                w_accept             = bus.req_valid[r_owner] & ~bus.full_flag;
                if (w_accept) begin
                    if (bus.req_last[r_owner] || (r_beat_cnt == CW'(MAX_BURST - 1))) begin
                        w_state_next    = IDLE;
                        w_grant_next    = '0;
                        w_last_idx_next = r_owner;
                        w_beat_cnt_next = '0;
                        w_pkt_done_next = 1'b1;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_last_idx <= IW'(NREQ - 1);
            r_beat_cnt <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_owner    <= w_owner_next;
            r_last_idx <= w_last_idx_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_pkt_done <= w_pkt_done_next;
        end
    end

    assign bus.wr_en     = w_accept;
    assign bus.wr_data   = bus.req_data[r_owner*WIDTH +: WIDTH];
    assign bus.req_ready = w_req_ready;
    assign bus.grant     = r_grant;
    assign bus.pkt_done  = r_pkt_done;
endmodule
